// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - inverse decoder for a 4-digit multiplexed active-low 7-segment bus
module seg7_decode #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 524288
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an_in,
  input  logic [6:0]  seg_in,
  input  logic        dp_in,
  output logic [15:0] value,
  output logic [3:0]  value_dp,
  output logic [3:0]  digit_err,
  output logic        frame_vld,
  output logic        frame_pls,
  output logic        blank,
  output logic        an_err
);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  // Capture fires on the edge where the stability count steps to SETTLE_CYC-1.
  localparam logic [7:0]  CAP_CNT = 8'(SETTLE_CYC - 2);
  localparam logic [19:0] TO_CNT  = 20'(TIMEOUT_CYC);

  state_t      state, state_nxt;
  logic [3:0]  an_r, an_p;
  logic [6:0]  seg_r, seg_p;
  logic        dp_r, dp_p;
  logic [7:0]  stab_cnt;
  logic [19:0] to_cnt;
  logic [3:0]  seen;
  logic [15:0] sh_val;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_err;

  logic        same;
  logic        an_valid;
  logic        an_multi;
  logic [1:0]  dig_idx;
  logic [3:0]  nib;
  logic        nib_bad;
  logic        capture;

  assign same     = ({an_r, seg_r, dp_r} == {an_p, seg_p, dp_p});
  assign an_multi = !an_valid && (an_r != 4'b1111);
  assign capture  = (state == SETTLE) && same && (stab_cnt == CAP_CNT);

  always_comb begin
    an_valid = 1'b1;
    dig_idx  = 2'd0;
    case (an_r)
      4'b1110: dig_idx = 2'd0;
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  always_comb begin
    nib     = 4'hF;
    nib_bad = 1'b0;
    case (seg_r)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0111111: nib = 4'hA;
      7'b1111111: nib = 4'hB;
      7'b1110111: nib = 4'hC;
      default:    nib_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (an_valid) state_nxt = SETTLE;
      SETTLE:  begin
        if (!same)        state_nxt = an_valid ? SETTLE : IDLE;
        else if (capture) state_nxt = HELD;
      end
      HELD:    if (!same) state_nxt = an_valid ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      an_r      <= 4'd0;
      an_p      <= 4'd0;
      seg_r     <= 7'd0;
      seg_p     <= 7'd0;
      dp_r      <= 1'b0;
      dp_p      <= 1'b0;
      stab_cnt  <= 8'd0;
      to_cnt    <= 20'd0;
      seen      <= 4'd0;
      sh_val    <= 16'd0;
      sh_dp     <= 4'd0;
      sh_err    <= 4'd0;
      value     <= 16'd0;
      value_dp  <= 4'd0;
      digit_err <= 4'd0;
      frame_vld <= 1'b0;
      frame_pls <= 1'b0;
      blank     <= 1'b0;
      an_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      an_r      <= an_in;
      seg_r     <= seg_in;
      dp_r      <= dp_in;
      an_p      <= an_r;
      seg_p     <= seg_r;
      dp_p      <= dp_r;
      blank     <= (an_r == 4'b1111);
      an_err    <= an_multi && (an_r != an_p);
      frame_pls <= 1'b0;

      if (!same)                  stab_cnt <= 8'd0;
      else if (stab_cnt != 8'hFF) stab_cnt <= stab_cnt + 8'd1;

      if (capture) begin
        sh_val[{dig_idx, 2'b00} +: 4] <= nib;
        sh_dp[dig_idx]  <= ~dp_r;
        sh_err[dig_idx] <= nib_bad;
        seen[dig_idx]   <= 1'b1;
        to_cnt          <= 20'd0;
      end else if (to_cnt != TO_CNT) begin
        to_cnt <= to_cnt + 20'd1;
      end

      // Stale frame: keep the last word visible but flag it invalid.
      if (!capture && to_cnt == TO_CNT) begin
        frame_vld <= 1'b0;
        seen      <= 4'd0;
      end

      if (seen == 4'b1111) begin
        value     <= sh_val;
        value_dp  <= sh_dp;
        digit_err <= sh_err;
        frame_vld <= 1'b1;
        frame_pls <= 1'b1;
        seen      <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_decode.sv
// tb/tb_seg7_decode.sv - directed self-checking bench for seg7_decode
module tb_seg7_decode;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100,
                         P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010,
                         P7 = 7'b1111000, P8 = 7'b0000000, P9 = 7'b0010000,
                         PA = 7'b0111111, PB = 7'b1111111, PC = 7'b1110111,
                         PBAD = 7'b1010101;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic        dp_in;
  logic [15:0] value;
  logic [3:0]  value_dp;
  logic [3:0]  digit_err;
  logic        frame_vld;
  logic        frame_pls;
  logic        blank;
  logic        an_err;

  int n_cmp = 0;
  int n_bad = 0;
  int pls_cnt = 0;
  int err_cnt = 0;
  int dbl_cnt = 0;
  logic pls_q = 1'b0;

  seg7_decode #(.SETTLE_CYC(16), .TIMEOUT_CYC(400)) dut (
    .clk(clk), .rst(rst), .an_in(an_in), .seg_in(seg_in), .dp_in(dp_in),
    .value(value), .value_dp(value_dp), .digit_err(digit_err),
    .frame_vld(frame_vld), .frame_pls(frame_pls), .blank(blank), .an_err(an_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_pls) pls_cnt++;
    if (an_err) err_cnt++;
    if (frame_pls && pls_q) dbl_cnt++;
    pls_q = frame_pls;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one digit for n cycles; returns the cycle (1-based) of the first frame_pls seen.
  task automatic dwell(input int idx, input logic [6:0] s, input logic dp, input int n,
                       output int first_pls);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    an_in = ~oh;
    seg_in = s;
    dp_in = dp;
    first_pls = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (frame_pls && first_pls == 0) first_pls = i;
    end
  endtask

  task automatic hold_an(input logic [3:0] a, input int n);
    an_in = a;
    seg_in = PB;
    dp_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int fp;
    int base;
    int ebase;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      an_in = 4'($urandom);
      seg_in = 7'($urandom);
      dp_in = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_value", value, 16'h0);
    chk("rst_dp", value_dp, 4'h0);
    chk("rst_err", digit_err, 4'h0);
    chk("rst_flags", {frame_vld, frame_pls, blank, an_err}, 4'h0);
    an_in = 4'b1111;
    rst = 1'b0;
    hold_an(4'b1111, 5);

    base = pls_cnt;
    dwell(0, P4, 1'b1, 32, fp);
    dwell(1, P3, 1'b1, 32, fp);
    dwell(2, P2, 1'b0, 32, fp);
    chk("vld_partial", frame_vld, 1'b0);
    dwell(3, P1, 1'b1, 32, fp);
    chk("nom_pls_cycle", fp, 18);
    chk("nom_pls_count", pls_cnt - base, 1);
    chk("nom_value", value, 16'h1234);
    chk("nom_dp", value_dp, 4'b0100);
    chk("nom_err", digit_err, 4'h0);
    chk("nom_vld", frame_vld, 1'b1);

    base = pls_cnt;
    an_in = 4'b1110;
    dp_in = 1'b1;
    for (int k = 0; k < 25; k++) begin
      seg_in = k[0] ? P8 : P4;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
      end
    end
    dwell(3, P1, 1'b1, 32, fp);
    dwell(2, P2, 1'b1, 32, fp);
    dwell(1, P3, 1'b1, 32, fp);
    chk("glitch_no_frame", pls_cnt - base, 0);
    chk("glitch_value_kept", value, 16'h1234);
    dwell(0, P7, 1'b1, 32, fp);
    chk("glitch_after_pls", fp, 18);
    chk("glitch_after_value", value, 16'h1237);
    chk("glitch_after_dp", value_dp, 4'h0);

    dwell(0, P9, 1'b1, 32, fp);
    dwell(1, PA, 1'b1, 32, fp);
    dwell(2, PBAD, 1'b1, 32, fp);
    dwell(3, PB, 1'b1, 32, fp);
    chk("bad_value", value, 16'hBFA9);
    chk("bad_err", digit_err, 4'b0100);

    dwell(0, P4, 1'b1, 32, fp);
    dwell(1, P3, 1'b1, 32, fp);
    dwell(2, P2, 1'b0, 32, fp);
    dwell(3, P1, 1'b1, 32, fp);
    chk("renom_value", value, 16'h1234);
    chk("renom_err", digit_err, 4'h0);

    base = pls_cnt;
    ebase = err_cnt;
    hold_an(4'b1100, 40);
    chk("multi_an_err", err_cnt - ebase, 1);
    chk("multi_no_frame", pls_cnt - base, 0);
    chk("multi_value", value, 16'h1234);

    hold_an(4'b1111, 20);
    chk("blank_early", blank, 1'b1);
    chk("vld_before_to", frame_vld, 1'b1);
    hold_an(4'b1111, 400);
    chk("to_vld", frame_vld, 1'b0);
    chk("to_value", value, 16'h1234);
    chk("to_blank", blank, 1'b1);

    dwell(0, P8, 1'b1, 32, fp);
    dwell(1, P8, 1'b1, 32, fp);
    an_in = 4'b1111;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_value", value, 16'h0);
    chk("mid_rst_vld", frame_vld, 1'b0);
    base = pls_cnt;
    dwell(2, PA, 1'b1, 32, fp);
    dwell(3, P0, 1'b1, 32, fp);
    chk("mid_rst_no_stale", pls_cnt - base, 0);
    dwell(0, PC, 1'b1, 32, fp);
    dwell(1, P5, 1'b1, 32, fp);
    chk("mid_rst_pls", fp, 18);
    chk("mid_rst_new_value", value, 16'h0A5C);
    chk("mid_rst_new_vld", frame_vld, 1'b1);

    chk("pls_never_back_to_back", dbl_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
